state_dump: RTL and testbench

- Hardware readback engine for the single-cycle MIPS core's architectural state.
- On a start request it stalls the CPU and reads all 32 registers, then the first MEM_WORDS data-memory words.
- Each word is streamed out as bytes over a valid/ready interface.
- This is the read/export side of the state that is loaded into the register file and data memory at bring-up; it lets silicon or FPGA builds dump state without simulator file I/O.

---
 rtl/state_dump_pkg.sv | 18 +
 rtl/state_dump_if.sv | 12 +
 rtl/state_dump_word_serializer.sv | 56 +++++
 rtl/state_dump.sv | 174 +++++++++++++++++
 tb/tb_state_dump.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/state_dump_pkg.sv
// state_dump_pkg: shared types and constants for the architectural state dump engine.
package state_dump_pkg;

  localparam int unsigned DUMP_DATA_W    = 32;
  localparam int unsigned BYTES_PER_WORD = DUMP_DATA_W / 8;
  localparam int unsigned REG_ADDR_W     = 5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REG_RD   = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_WAIT = 3'd3,
    SEND     = 3'd4,
    CSUM     = 3'd5,
    DONE     = 3'd6
  } state_e;

endpackage

// File: rtl/state_dump_if.sv
// state_dump_if: byte stream from the dump engine to its downstream consumer.
interface state_dump_if;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);

endinterface

// File: rtl/state_dump_word_serializer.sv
// word_serializer: loads one word and emits it MSB-first as bytes under valid/ready.
module word_serializer #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic [7:0]        data,
  output logic              last,
  output logic              word_done_c
);

  localparam int unsigned BPW   = DATA_W / 8;
  localparam int unsigned CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPW - 1);

  logic [DATA_W-1:0] shreg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              word_last_q;

  // Top byte of the shift register is the byte on offer.
  assign data        = shreg_q[DATA_W-1 -: 8];
  assign word_done_c = valid && ready && (cnt_q == CNT_LAST);

  // Shift one byte per handshake; everything holds while the consumer stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q     <= '0;
      cnt_q       <= '0;
      valid       <= 1'b0;
      last        <= 1'b0;
      word_last_q <= 1'b0;
    end else if (load) begin
      shreg_q     <= load_data;
      cnt_q       <= '0;
      valid       <= 1'b1;
      word_last_q <= load_last;
      last        <= load_last && (BPW == 1);
    end else if (valid && ready) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        valid <= 1'b0;
        last  <= 1'b0;
      end else begin
        shreg_q <= shreg_q << 8;
        cnt_q   <= cnt_q + 1'b1;
        last    <= word_last_q && ((cnt_q + 1'b1) == CNT_LAST);
      end
    end
  end

endmodule

// File: rtl/state_dump.sv
// state_dump: stalls the core and streams all registers then data memory as a byte frame.
// Optional STATE_DUMP_CHECKSUM_EN appends an XOR checksum byte carrying out_last.
module state_dump
  import state_dump_pkg::*;
#(
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned MEM_WORDS  = 256,
  parameter int unsigned MEM_ADDR_W = 18,
  parameter int unsigned DATA_W     = DUMP_DATA_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  dump_start,
  output logic                  dump_busy,
  output logic                  dump_done,
  output logic                  cpu_stall,
  output logic [REG_ADDR_W-1:0] reg_rd_addr,
  input  logic [DATA_W-1:0]     reg_rd_data,
  output logic                  mem_rd_en,
  output logic [MEM_ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0]     mem_rd_data,
  state_dump_if.master          stream
);

  localparam int unsigned RIDX_W = (REG_COUNT > 0) ? $clog2(REG_COUNT + 1) : 1;
  localparam int unsigned MIDX_W = (MEM_WORDS > 0) ? $clog2(MEM_WORDS + 1) : 1;
  localparam logic [RIDX_W-1:0] REG_LAST = RIDX_W'((REG_COUNT > 0) ? REG_COUNT - 1 : 0);
  localparam logic [RIDX_W-1:0] REG_END  = RIDX_W'(REG_COUNT);
  localparam logic [MIDX_W-1:0] MEM_LAST = MIDX_W'((MEM_WORDS > 0) ? MEM_WORDS - 1 : 0);
  localparam logic HAS_REGS = (REG_COUNT > 0);
  localparam logic HAS_MEM  = (MEM_WORDS > 0);

`ifdef STATE_DUMP_CHECKSUM_EN
  localparam state_e FINAL_ST        = CSUM;
  localparam logic   PAYLOAD_LAST_EN = 1'b0;
`else
  localparam state_e FINAL_ST        = DONE;
  localparam logic   PAYLOAD_LAST_EN = 1'b1;
`endif

  state_e            state_q, state_d;
  logic [RIDX_W-1:0] reg_idx_q, reg_idx_d;
  logic [MIDX_W-1:0] mem_idx_q, mem_idx_d;
  logic              ser_load_c;
  logic [DATA_W-1:0] ser_word_c;
  logic              ser_last_c;
  logic              ser_valid;
  logic [7:0]        ser_data;
  logic              ser_last;
  logic              ser_done_c;

  assign cpu_stall = dump_busy;

  word_serializer #(.DATA_W(DATA_W)) u_ser (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (ser_load_c),
    .load_data   (ser_word_c),
    .load_last   (ser_last_c),
    .ready       (stream.out_ready),
    .valid       (ser_valid),
    .data        (ser_data),
    .last        (ser_last),
    .word_done_c (ser_done_c)
  );

  // Next-state and word sequencing: registers first, then memory; reg_idx == REG_END marks memory phase.
  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    mem_idx_d  = mem_idx_q;
    ser_load_c = 1'b0;
    ser_word_c = reg_rd_data;
    ser_last_c = 1'b0;
    case (state_q)
      IDLE: begin
        reg_idx_d = '0;
        mem_idx_d = '0;
        if (dump_start) begin
          if (HAS_REGS)     state_d = REG_RD;
          else if (HAS_MEM) state_d = MEM_REQ;
          else              state_d = FINAL_ST;
        end
      end
      REG_RD: begin
        ser_load_c = 1'b1;
        ser_word_c = reg_rd_data;
        ser_last_c = PAYLOAD_LAST_EN && !HAS_MEM && (reg_idx_q == REG_LAST);
        state_d    = SEND;
      end
      MEM_REQ: state_d = MEM_WAIT;
      MEM_WAIT: begin
        ser_load_c = 1'b1;
        ser_word_c = mem_rd_data;
        ser_last_c = PAYLOAD_LAST_EN && (mem_idx_q == MEM_LAST);
        state_d    = SEND;
      end
      SEND: begin
        if (ser_done_c) begin
          if (reg_idx_q != REG_END) begin
            reg_idx_d = reg_idx_q + 1'b1;
            if (reg_idx_q == REG_LAST) state_d = HAS_MEM ? MEM_REQ : FINAL_ST;
            else                       state_d = REG_RD;
          end else if (mem_idx_q == MEM_LAST) begin
            state_d = FINAL_ST;
          end else begin
            mem_idx_d = mem_idx_q + 1'b1;
            state_d   = MEM_REQ;
          end
        end
      end
`ifdef STATE_DUMP_CHECKSUM_EN
      CSUM: begin
        if (stream.out_ready) state_d = DONE;
      end
`endif
      DONE: begin
        reg_idx_d = '0;
        mem_idx_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered control outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      reg_idx_q   <= '0;
      mem_idx_q   <= '0;
      dump_busy   <= 1'b0;
      dump_done   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      reg_rd_addr <= '0;
    end else begin
      state_q     <= state_d;
      reg_idx_q   <= reg_idx_d;
      mem_idx_q   <= mem_idx_d;
      dump_busy   <= (state_d != IDLE) && (state_d != DONE);
      dump_done   <= (state_d == DONE);
      mem_rd_en   <= (state_d == MEM_REQ);
      mem_rd_addr <= MEM_ADDR_W'(mem_idx_d);
      reg_rd_addr <= REG_ADDR_W'(reg_idx_d);
    end
  end

`ifdef STATE_DUMP_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       csum_valid_q;

  // XOR of every accepted payload byte; offered as a trailing byte in CSUM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      csum_q       <= '0;
      csum_valid_q <= 1'b0;
    end else begin
      if (state_d == IDLE)                    csum_q <= '0;
      else if (ser_valid && stream.out_ready) csum_q <= csum_q ^ ser_data;
      csum_valid_q <= (state_d == CSUM);
    end
  end

  assign stream.out_valid = ser_valid | csum_valid_q;
  assign stream.out_data  = csum_valid_q ? csum_q : ser_data;
  assign stream.out_last  = csum_valid_q | ser_last;
`else
  assign stream.out_valid = ser_valid;
  assign stream.out_data  = ser_data;
  assign stream.out_last  = ser_last;
`endif

endmodule

// File: tb/tb_state_dump.sv
// tb_state_dump: directed checks of the state dump frame, handshake hold, stall and reset behaviour.
module tb_state_dump;

`ifdef STATE_DUMP_CHECKSUM_EN
  localparam int FRAME = 1153;
`else
  localparam int FRAME = 1152;
`endif
  localparam int GAPS = 32 + 2 * 256;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        dump_start;
  logic        dump_busy, dump_done, cpu_stall;
  logic [4:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic        mem_rd_en;
  logic [17:0] mem_rd_addr;
  logic [31:0] mem_rd_data;

  state_dump_if dif();

  state_dump dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .dump_start  (dump_start),
    .dump_busy   (dump_busy),
    .dump_done   (dump_done),
    .cpu_stall   (cpu_stall),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_data (reg_rd_data),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .stream      (dif)
  );

  always #5 clock = ~clock;

  logic [31:0] regs [32];
  logic [31:0] mem  [256];

  assign reg_rd_data = regs[reg_rd_addr];
  always @(posedge clock) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[7:0]];

  int n_cmp = 0;
  int n_err = 0;
  bit rnd_mode = 1'b0;

  // Consumer ready: always high, or low about 30% of cycles.
  always @(posedge clock) begin
    #1;
    dif.out_ready = rnd_mode ? ($urandom_range(0, 9) > 2) : 1'b1;
  end

  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int cyc = 0;
  int stab_err, stall_err, gap_cnt, hold_cnt;
  int mem_cnt, mem_exp, mem_addr_err, mem_pulse_err;
  int last_cnt, last_idx, last_cyc, done_cnt, done_cyc;
  bit prev_hold, prev_en;
  logic [7:0] hold_data;
  logic hold_last;

  // Observe the values that the next rising edge will act on.
  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      prev_hold = 1'b0;
      prev_en   = 1'b0;
    end else begin
      if (prev_hold && (!dif.out_valid || dif.out_data !== hold_data || dif.out_last !== hold_last))
        stab_err++;
      prev_hold = dif.out_valid && !dif.out_ready;
      if (prev_hold) hold_cnt++;
      hold_data = dif.out_data;
      hold_last = dif.out_last;
      if (dif.out_valid && !cpu_stall) stall_err++;
      if (cpu_stall !== dump_busy) stall_err++;
      if (dump_busy && !dif.out_valid) gap_cnt++;
      if (mem_rd_en) begin
        if (prev_en) mem_pulse_err++;
        if (mem_rd_addr !== 18'(mem_exp)) mem_addr_err++;
        mem_exp++;
        mem_cnt++;
      end
      prev_en = mem_rd_en;
      if (dif.out_valid && dif.out_ready) begin
        got_q.push_back(dif.out_data);
        if (dif.out_last) begin
          last_cnt++;
          last_idx = got_q.size() - 1;
          last_cyc = cyc;
        end
      end
      if (dump_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    stab_err = 0; stall_err = 0; gap_cnt = 0; hold_cnt = 0;
    mem_cnt = 0; mem_exp = 0; mem_addr_err = 0; mem_pulse_err = 0;
    last_cnt = 0; last_idx = -1; last_cyc = -1; done_cnt = 0; done_cyc = -1;
  endtask

  task automatic build_exp();
    logic [7:0] x;
    x = 8'h00;
    exp_q.delete();
    for (int r = 0; r < 32; r++)
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(regs[r][8*b +: 8]);
        x = x ^ regs[r][8*b +: 8];
      end
    for (int m = 0; m < 256; m++)
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(mem[m][8*b +: 8]);
        x = x ^ mem[m][8*b +: 8];
      end
`ifdef STATE_DUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 dump_start = 1'b1;
    @(posedge clock); #1 dump_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < 20000) begin
      @(posedge clock);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    int berr;
    berr = 0;
    build_exp();
    chk({tag, "_len"}, 32'(got_q.size()), 32'(FRAME));
    for (int i = 0; i < FRAME; i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) berr++;
    chk({tag, "_bytes_bad"}, 32'(berr), 32'd0);
    chk({tag, "_last_cnt"}, 32'(last_cnt), 32'd1);
    chk({tag, "_last_idx"}, 32'(last_idx), 32'(FRAME - 1));
    chk({tag, "_done_lat"}, 32'(done_cyc - last_cyc), 32'd1);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_mem_cnt"}, 32'(mem_cnt), 32'd256);
    chk({tag, "_mem_addr"}, 32'(mem_addr_err), 32'd0);
    chk({tag, "_mem_pulse"}, 32'(mem_pulse_err), 32'd0);
    chk({tag, "_stall"}, 32'(stall_err), 32'd0);
    chk({tag, "_hold"}, 32'(stab_err), 32'd0);
    chk({tag, "_gaps"}, 32'(gap_cnt), 32'(GAPS));
  endtask

  initial begin
    reset_n    = 1'b0;
    dump_start = 1'b0;
    dif.out_ready = 1'b1;
    foreach (regs[i]) regs[i] = 32'h0;
    foreach (mem[i])  mem[i]  = 32'h0;
    regs[1]  = 32'h12345678;
    regs[31] = 32'hDEADBEEF;
    mem[0]   = 32'h000000FF;
    clear_mon();

    // Reset values while reset is held.
    #12;
    chk("rst_busy",  32'(dump_busy),     32'd0);
    chk("rst_done",  32'(dump_done),     32'd0);
    chk("rst_stall", 32'(cpu_stall),     32'd0);
    chk("rst_men",   32'(mem_rd_en),     32'd0);
    chk("rst_valid", 32'(dif.out_valid), 32'd0);
    chk("rst_last",  32'(dif.out_last),  32'd0);
    chk("rst_data",  32'(dif.out_data),  32'd0);
    chk("rst_raddr", 32'(reg_rd_addr),   32'd0);
    chk("rst_maddr", 32'(mem_rd_addr),   32'd0);
    @(negedge clock) reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // Frame 1: ready always high, latency and known byte positions.
    clear_mon();
    pulse_start();
    chk("lat1_busy",  32'(dump_busy),     32'd1);
    chk("lat1_valid", 32'(dif.out_valid), 32'd0);
    chk("lat1_raddr", 32'(reg_rd_addr),   32'd0);
    @(posedge clock); #1;
    chk("lat2_valid", 32'(dif.out_valid), 32'd1);
    chk("lat2_data",  32'(dif.out_data),  32'h00);
    wait_done(1, "f1");
    check_frame("f1");
    chk("f1_b4",   32'(got_q[4]),   32'h12);
    chk("f1_b5",   32'(got_q[5]),   32'h34);
    chk("f1_b6",   32'(got_q[6]),   32'h56);
    chk("f1_b7",   32'(got_q[7]),   32'h78);
    chk("f1_b124", 32'(got_q[124]), 32'hDE);
    chk("f1_b125", 32'(got_q[125]), 32'hAD);
    chk("f1_b126", 32'(got_q[126]), 32'hBE);
    chk("f1_b127", 32'(got_q[127]), 32'hEF);
    chk("f1_b128", 32'(got_q[128]), 32'h00);
    chk("f1_b131", 32'(got_q[131]), 32'hFF);
    #1;
    chk("f1_idle_busy", 32'(dump_busy), 32'd0);

    // Frame 2: ready low about 30% of cycles; same stream, held outputs.
    repeat (3) @(posedge clock);
    clear_mon();
    rnd_mode = 1'b1;
    pulse_start();
    wait_done(1, "rnd");
    rnd_mode = 1'b0;
    begin
      int berr;
      berr = 0;
      build_exp();
      chk("rnd_len", 32'(got_q.size()), 32'(FRAME));
      for (int i = 0; i < FRAME; i++)
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) berr++;
      chk("rnd_bytes_bad", 32'(berr), 32'd0);
      chk("rnd_hold",  32'(stab_err), 32'd0);
      chk("rnd_held_some", 32'(hold_cnt > 0), 32'd1);
      chk("rnd_last_idx", 32'(last_idx), 32'(FRAME - 1));
      chk("rnd_mem_addr", 32'(mem_addr_err), 32'd0);
      chk("rnd_stall", 32'(stall_err), 32'd0);
    end

    // dump_start held high: one frame, then a second begins from IDLE.
    repeat (3) @(posedge clock);
    clear_mon();
    #1 dump_start = 1'b1;
    wait_done(1, "hold1");
    chk("hold1_len", 32'(got_q.size()), 32'(FRAME));
    chk("hold1_done_cnt", 32'(done_cnt), 32'd1);
    clear_mon();
    #1;
    chk("hold_idle_busy", 32'(dump_busy), 32'd0);
    @(posedge clock); #1;
    chk("hold_restart_busy", 32'(dump_busy), 32'd1);
    dump_start = 1'b0;
    wait_done(1, "hold2");
    check_frame("hold2");

    // Reset asserted mid-frame at byte 500.
    repeat (3) @(posedge clock);
    clear_mon();
    pulse_start();
    begin
      int n;
      n = 0;
      while (got_q.size() < 500 && n < 5000) begin
        @(posedge clock);
        n++;
      end
    end
    chk("mid_reached", 32'(got_q.size() >= 500), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_valid", 32'(dif.out_valid), 32'd0);
    chk("mid_data",  32'(dif.out_data),  32'd0);
    chk("mid_last",  32'(dif.out_last),  32'd0);
    chk("mid_busy",  32'(dump_busy),     32'd0);
    chk("mid_stall", 32'(cpu_stall),     32'd0);
    chk("mid_men",   32'(mem_rd_en),     32'd0);
    chk("mid_no_done", 32'(done_cnt),    32'd0);
    chk("mid_no_last", 32'(last_cnt),    32'd0);
    @(negedge clock) reset_n = 1'b1;
    repeat (2) @(posedge clock);
    clear_mon();
    pulse_start();
    wait_done(1, "post");
    check_frame("post");

    // Sparse state: only r1 = 01020304 (checksum byte 04 when enabled).
    foreach (regs[i]) regs[i] = 32'h0;
    foreach (mem[i])  mem[i]  = 32'h0;
    regs[1] = 32'h01020304;
    repeat (3) @(posedge clock);
    clear_mon();
    pulse_start();
    wait_done(1, "sp");
    check_frame("sp");
    chk("sp_b4", 32'(got_q[4]), 32'h01);
    chk("sp_b7", 32'(got_q[7]), 32'h04);
`ifdef STATE_DUMP_CHECKSUM_EN
    chk("sp_csum", 32'(got_q[1152]), 32'h04);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
